// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch redirect flushes and memory-wait freezes,
// with stall/flush statistics and a sticky memory-timeout flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | previous cycle advanced normally
// BUBBLE  | previous cycle inserted a load-use bubble into decode/execute
// FLUSH   | previous cycle applied a redirect and flushed fetch/decode
// MEMWAIT | previous cycle froze the pipeline waiting on data memory
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pipe_ce,
    output logic        pc_we,
    output logic        fd_we,
    output logic        fd_flush,
    output logic        de_ena,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BUBBLE  = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } state_e;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] stall_q;
    logic [15:0] flush_q;
    logic [15:0] wait_q, wait_d;
    logic        timeout_q;

    logic load_use;
    logic mem_stall;
    logic stall_inc;
    logic flush_apply;
    logic timeout_hit;

    assign load_use  = ex_is_load && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
    // mem_ready only matters while an access is actually outstanding
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        pipe_ce     = 1'b1;
        pc_we       = 1'b1;
        fd_we       = 1'b1;
        fd_flush    = 1'b0;
        de_ena      = 1'b1;
        state_d     = RUN;
        stall_inc   = 1'b0;
        flush_apply = 1'b0;

        if (rst) begin
            fd_flush = 1'b1;
            de_ena   = 1'b0;
        end else if (mem_stall) begin
            // frozen inputs hold any pending redirect until the access completes
            pipe_ce   = 1'b0;
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            state_d   = MEMWAIT;
            stall_inc = 1'b1;
        end else if (ex_redirect) begin
            fd_flush    = 1'b1;
            de_ena      = 1'b0;
            state_d     = FLUSH;
            flush_apply = 1'b1;
        end else if (load_use) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            de_ena    = 1'b0;
            state_d   = BUBBLE;
            stall_inc = 1'b1;
        end
    end

    always_comb begin
        wait_d = 16'd0;
        if (state_q == MEMWAIT) begin
            wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
        end
    end

    assign timeout_hit = (state_q == MEMWAIT) && (wait_q != 16'hFFFF) &&
                         (({1'b0, wait_q} + 17'd1) == TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            stall_q   <= 32'd0;
            flush_q   <= 16'd0;
            wait_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stall_inc) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush_apply && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of consecutive MEMWAIT cycles after which mem_timeout sets.
REQ-002 SHALL have the following ports, listed as name, direction, width, meaning.
- clk, in, 1: single clock; all state updates on its posedge.
- rst, in, 1: synchronous, active-high reset.
- id_rs1, id_rs2, in, 5 each: source registers of the instruction in decode.
- id_use_rs1, id_use_rs2, in, 1 each: decode instruction reads rs1 / rs2.
- ex_rd, in, 5: destination register of the instruction in execute.
- ex_is_load, in, 1: execute instruction is a load.
- ex_redirect, in, 1: taken branch or jump resolved in execute.
- mem_req, in, 1: data-memory access active in the MEM stage.
- mem_ready, in, 1: data memory completes the access this cycle.
- pipe_ce, out, 1: global advance enable for all stage latches; 0 freezes them.
- pc_we, out, 1: PC register write enable.
- fd_we, out, 1: fetch/decode latch write enable; 0 holds the latch.
- fd_flush, out, 1: replace the fetch/decode latch with a NOP.
- de_ena, out, 1: drives the decode/execute latch ena; 0 loads zeros, i.e. a bubble.
- state, out, 2: encoded as RUN=0, BUBBLE=1, FLUSH=2, MEMWAIT=3.
- stall_cycles, out, 32: count of cycles with pipe_ce=0 or a load-use bubble.
- flush_count, out, 16: count of redirects taken.
- mem_timeout, out, 1: sticky memory-timeout flag.

Function
REQ-003 SHALL define load_use = ex_is_load & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-004 SHALL define mem_stall = mem_req & ~mem_ready.
REQ-005 SHALL decode the outputs combinationally from the current inputs with the priority mem_stall > ex_redirect > load_use > none.
REQ-006 On mem_stall, the outputs SHALL be pipe_ce=0, pc_we=0, fd_we=0, fd_flush=0, de_ena=1, and the next state SHALL be MEMWAIT.
REQ-007 On ex_redirect without mem_stall, the outputs SHALL be pipe_ce=1, pc_we=1, fd_we=1, fd_flush=1, de_ena=0, and the next state SHALL be FLUSH.
REQ-008 On load_use alone, the outputs SHALL be pipe_ce=1, pc_we=0, fd_we=0, fd_flush=0, de_ena=0, and the next state SHALL be BUBBLE.
REQ-009 With no condition active, all enables SHALL be 1, fd_flush SHALL be 0, and the next state SHALL be RUN.
REQ-010 The state register SHALL record the condition decoded in the previous cycle; BUBBLE and FLUSH therefore last exactly one cycle unless re-triggered.
REQ-011 The block SHALL never suppress load_use detection on the basis of state; ex_rd after a bubble is 0, so no duplicate bubble results.
REQ-012 ex_redirect together with load_use SHALL resolve as a redirect only; the dependent instruction is flushed.
REQ-013 ex_redirect during mem_stall SHALL be held off and taken on the first cycle in which mem_stall=0, since the inputs remain frozen.
REQ-014 stall_cycles SHALL increment by 1 in every cycle with mem_stall or load_use (unflushed) and SHALL wrap modulo 2^32.
REQ-015 flush_count SHALL increment on each cycle in which ex_redirect is applied (REQ-007) and SHALL saturate at 0xFFFF.
REQ-016 A 16-bit wait counter SHALL clear in every cycle that is not in MEMWAIT and SHALL increment each consecutive MEMWAIT cycle, saturating.
REQ-017 mem_timeout SHALL set on the cycle the wait counter reaches TIMEOUT and SHALL remain 1 until reset; pipeline control is unaffected.
REQ-018 mem_ready without mem_req SHALL be ignored.

Reset
REQ-019 While rst=1 at a clock edge, state, stall_cycles, flush_count, the wait counter and mem_timeout SHALL all be 0 after that edge.
REQ-020 While rst=1, the combinational outputs SHALL be forced to pipe_ce=1, pc_we=1, fd_we=1, fd_flush=1, de_ena=0, flushing any in-flight instruction.
REQ-021 Reset asserted mid-MEMWAIT SHALL abandon the wait with no residual stall after rst falls.

Verification
REQ-022 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly one cycle with pc_we=fd_we=de_ena=0, then state=BUBBLE and stall_cycles=1.
REQ-023 x0: ex_is_load=1, ex_rd=0, id_rs1=0 -> no stall, state=RUN.
REQ-024 Redirect plus load_use in the same cycle -> fd_flush=1, de_ena=0, pc_we=1, flush_count=1, stall_cycles unchanged.
REQ-025 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_ce=0 for 3 cycles, stall_cycles=3, pipe_ce=1 on the 4th cycle.
REQ-026 Timeout: TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 on the 4th MEMWAIT cycle, still 1 after mem_ready=1, and cleared only by rst.
REQ-027 Reset mid-MEMWAIT with rst=1 for 1 cycle -> all counters 0, state=RUN, mem_timeout=0.
